// File: rtl/parallel_input.sv
// -----------------------------------------------------------------------------
// parallel_input
//   Memory-mapped general-purpose input port. Up to 32 asynchronous pins are
//   synchronised into the clk domain and their level is exposed on the bus.
//   Rising and falling edges are latched into sticky write-1-to-clear flags,
//   and a registered level interrupt is raised for enabled flags.
//
//   Register map (offset = addr[3:2], addr[1:0] ignored):
//     0 DATA   RO   synchronised pin levels
//     1 RISE   W1C  sticky rising-edge flags
//     2 FALL   W1C  sticky falling-edge flags
//     3 IRQ_EN RW   per-pin interrupt enable
//
//   Ports:
//     clk, rst_n      core clock, asynchronous active-low reset
//     addr/wdata      bus byte address / write data
//     wmask           byte write enables
//     ren/wen         read / write strobes
//     rdata           read data, valid while ready=1, held until next read
//     ready           registered single-cycle access-complete pulse
//     active          combinational address decode for this device slot
//     io              asynchronous external pins
//     irq             registered interrupt request
// -----------------------------------------------------------------------------

// Per-pin slice: synchroniser, delayed copy and the two sticky edge flags.
module parallel_input_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic io_i,
    input  logic cap_en_i,    // edge capture allowed (warm-up done)
    input  logic rise_clr_i,  // W1C clear of the rise flag this cycle
    input  logic fall_clr_i,  // W1C clear of the fall flag this cycle
    output logic data_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   data;
    logic                   rise_set, fall_set;

    assign data = sync_q[SYNC_STAGES-1];

    // A freshly detected edge takes priority over a clear in the same cycle.
    always_comb begin
        rise_set = cap_en_i & data & ~prev_q;
        fall_set = cap_en_i & ~data & prev_q;
        rise_d   = rise_set | (rise_q & ~rise_clr_i);
        fall_d   = fall_set | (fall_q & ~fall_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_i};
            prev_q <= data;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = data;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

module parallel_input #(
    parameter logic [31:0] BASE_ADDR   = 32'h0003_0000,
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wmask,
    input  logic             ren,
    input  logic             wen,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             active,
    input  logic [WIDTH-1:0] io,
    output logic             irq
);
    // Capture opens once the chain and prev hold real pin samples, so the
    // reset value of prev can never be mistaken for an edge.
    localparam int                CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  WARM_MAX = CNT_W'(SYNC_STAGES + 1);

    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_RISE = 2'd1;
    localparam logic [1:0] OFF_FALL = 2'd2;
    localparam logic [1:0] OFF_IREN = 2'd3;

    logic [CNT_W-1:0] warm_q, warm_d;
    logic [WIDTH-1:0] irqen_q, irqen_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] data_w, rise_w, fall_w;
    logic [WIDTH-1:0] rise_clr, fall_clr;
    logic [WIDTH-1:0] bmask, wbits;
    logic [31:0]      bmask32, rmux;
    logic [1:0]       off;
    logic             wr, rd, cap_en;

    // Slot is 16-byte aligned, so only the upper address bits decide.
    assign active = (addr[31:4] == BASE_ADDR[31:4]);
    assign off    = addr[3:2];
    assign wr     = wen & active;
    assign rd     = ren & active;
    assign cap_en = (warm_q == WARM_MAX);

    assign bmask32 = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    assign bmask   = bmask32[WIDTH-1:0];
    assign wbits   = wdata[WIDTH-1:0] & bmask;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        parallel_input_lane #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .io_i       (io[g]),
            .cap_en_i   (cap_en),
            .rise_clr_i (rise_clr[g]),
            .fall_clr_i (fall_clr[g]),
            .data_o     (data_w[g]),
            .rise_o     (rise_w[g]),
            .fall_o     (fall_w[g])
        );
    end

    always_comb begin
        warm_d   = (warm_q == WARM_MAX) ? warm_q : warm_q + 1'b1;
        rise_clr = (wr && off == OFF_RISE) ? wbits : '0;
        fall_clr = (wr && off == OFF_FALL) ? wbits : '0;
        irqen_d  = irqen_q;
        if (wr && off == OFF_IREN)
            irqen_d = (irqen_q & ~bmask) | wbits;

        // Read mux sees pre-edge values: same-cycle edges and writes are not
        // visible in the captured data.
        rmux = '0;
        case (off)
            OFF_DATA: rmux = 32'(data_w);
            OFF_RISE: rmux = 32'(rise_w);
            OFF_FALL: rmux = 32'(fall_w);
            OFF_IREN: rmux = 32'(irqen_q);
            default:  rmux = '0;
        endcase
        rdata_d = rd ? rmux : rdata_q;
        ready_d = (ren | wen) & active;
        irq_d   = |((rise_w | fall_w) & irqen_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q  <= '0;
            irqen_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            irqen_q <= irqen_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            irq_q   <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign irq   = irq_q;

    // Byte-offset bits and any wdata bits above WIDTH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};
endmodule

// File: tb/tb_parallel_input.sv
module tb_parallel_input;
    localparam logic [31:0] BASE = 32'h0003_0000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_RISE = BASE + 32'd4;
    localparam logic [31:0] A_FALL = BASE + 32'd8;
    localparam logic [31:0] A_IREN = BASE + 32'd12;

    logic        clk, rst_n;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask;
    logic        ren, wen, ready, active, irq;
    logic [31:0] io;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state for the randomized test: flags derived from pin history.
    logic [31:0] m_rise, m_fall, m_en;

    parallel_input #(.BASE_ADDR(BASE), .WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
        .ren(ren), .wen(wen), .rdata(rdata), .ready(ready), .active(active),
        .io(io), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus helpers: called at a negedge, return at the following negedge
    // (one cycle after the access edge, when ready/rdata are visible).
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rdy);
        addr = a; ren = 1'b1;
        @(negedge clk);
        d = rdata; rdy = ready;
        ren = 1'b0; addr = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        addr = a; wdata = wd; wmask = wm; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0; wmask = 4'h0; addr = 32'h0;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic r;
        io = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({ready, rdata, irq} !== 34'h0) $display("FAIL reset_outs got %h exp 0", {ready, rdata, irq}); else n_pass++;
        rst_n = 1'b1;                // edge 1 follows
        @(posedge clk); @(posedge clk); @(negedge clk);
        bus_read(A_DATA, d, r);      // access edge 3 sees DATA after edge 2
        n_checks++; if (d !== 32'hFFFF_FFFF || r !== 1'b1) $display("FAIL reset_data got %h/%b exp ffffffff/1", d, r); else n_pass++;
        bus_write(A_IREN, 32'hFFFF_FFFF, 4'hF);
        repeat (4) @(negedge clk);
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_rise got %h exp 0", d); else n_pass++;
        bus_read(A_FALL, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_fall got %h exp 0", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
        bus_write(A_IREN, 32'h0, 4'hF);
    endtask

    task automatic test_latency;
        logic [31:0] d; logic r;
        io = 32'h0;
        repeat (5) @(negedge clk);
        bus_write(A_RISE, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_FALL, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_IREN, 32'h8, 4'hF);
        @(negedge clk);
        io = 32'h8;                  // stable before edge k
        @(negedge clk);              // after edge k
        bus_read(A_DATA, d, r);      // access k+1, sees DATA after k
        n_checks++; if (d !== 32'h0) $display("FAIL lat_data_early got %h exp 0", d); else n_pass++;
        bus_read(A_DATA, d, r);      // access k+2, sees DATA after k+1
        n_checks++; if (d !== 32'h8) $display("FAIL lat_data got %h exp 8", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL lat_irq_early got %b exp 0", irq); else n_pass++;
        bus_read(A_RISE, d, r);      // access k+3, sees RISE after k+2
        n_checks++; if (d !== 32'h8 || r !== 1'b1) $display("FAIL lat_rise got %h/%b exp 8/1", d, r); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL lat_irq got %b exp 1", irq); else n_pass++;
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) $display("FAIL lat_ready_pulse got %b exp 0", ready); else n_pass++;
    endtask

    task automatic test_w1c;
        logic [31:0] d; logic r;
        io = 32'h9;
        repeat (4) @(negedge clk);
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h9) $display("FAIL w1c_pre got %h exp 9", d); else n_pass++;
        bus_write(A_RISE, 32'h1, 4'hF);
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h8) $display("FAIL w1c_clear got %h exp 8", d); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL w1c_irq got %b exp 1", irq); else n_pass++;
    endtask

    task automatic test_collision;
        logic [31:0] d; logic r;
        io = 32'h1;                  // drop pin 3, re-set rise bit 0 stays clear
        repeat (4) @(negedge clk);
        bus_write(A_RISE, 32'h8, 4'hF);
        bus_write(A_FALL, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL coll_pre got %h exp 0", d); else n_pass++;
        @(negedge clk);
        io = 32'h9;                  // before edge k, rise captured at k+2
        @(negedge clk); @(negedge clk);
        bus_write(A_RISE, 32'h8, 4'hF);  // access edge k+2
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h8) $display("FAIL coll_set_wins got %h exp 8", d); else n_pass++;
        bus_write(A_RISE, 32'h8, 4'hF);
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL coll_later_clear got %h exp 0", d); else n_pass++;
    endtask

    task automatic test_mask;
        logic [31:0] d; logic r;
        bus_write(A_IREN, 32'h0, 4'hF);
        bus_write(A_IREN, 32'hAABB_CCDD, 4'b0101);
        bus_read(A_IREN, d, r);
        n_checks++; if (d !== 32'h00BB_00DD) $display("FAIL mask_iren got %h exp 00bb00dd", d); else n_pass++;
        bus_write(A_DATA, 32'h1234_5678, 4'hF);
        bus_read(A_DATA, d, r);
        n_checks++; if (d !== io) $display("FAIL data_ro got %h exp %h", d, io); else n_pass++;
    endtask

    task automatic test_decode;
        logic seen;
        seen = 1'b0;
        addr = BASE + 32'd16; ren = 1'b1;
        #1;
        n_checks++; if (active !== 1'b0) $display("FAIL dec_active_hi got %b exp 0", active); else n_pass++;
        @(negedge clk); ren = 1'b0; addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (ready) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL dec_ready got %b exp 0", seen); else n_pass++;
        addr = BASE + 32'd12; #1;
        n_checks++; if (active !== 1'b1) $display("FAIL dec_active_top got %b exp 1", active); else n_pass++;
        addr = BASE - 32'd1; #1;
        n_checks++; if (active !== 1'b0) $display("FAIL dec_active_lo got %b exp 0", active); else n_pass++;
        addr = 32'h0;
    endtask

    task automatic test_back_to_back;
        addr = A_DATA; ren = 1'b1;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || rdata !== io) $display("FAIL b2b_first got %b/%h exp 1/%h", ready, rdata, io); else n_pass++;
        addr = A_IREN;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || rdata !== 32'h00BB_00DD) $display("FAIL b2b_second got %b/%h exp 1/00bb00dd", ready, rdata); else n_pass++;
        ren = 1'b0; addr = 32'h0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b0 || rdata !== 32'h00BB_00DD) $display("FAIL b2b_hold got %b/%h exp 0/00bb00dd", ready, rdata); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] d, nv, ov, clr; logic r;
        repeat (4) @(negedge clk);
        bus_write(A_RISE, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_FALL, 32'hFFFF_FFFF, 4'hF);
        m_rise = 32'h0; m_fall = 32'h0;
        ov = io;
        for (int it = 0; it < 16; it++) begin
            nv = $urandom;
            io = nv;
            repeat (4) @(negedge clk);   // every change settles and is captured
            m_rise |= nv & ~ov;
            m_fall |= ~nv & ov;
            ov = nv;
            bus_read(A_DATA, d, r);
            n_checks++; if (d !== nv) $display("FAIL rnd_data[%0d] got %h exp %h", it, d, nv); else n_pass++;
            bus_read(A_RISE, d, r);
            n_checks++; if (d !== m_rise) $display("FAIL rnd_rise[%0d] got %h exp %h", it, d, m_rise); else n_pass++;
            bus_read(A_FALL, d, r);
            n_checks++; if (d !== m_fall) $display("FAIL rnd_fall[%0d] got %h exp %h", it, d, m_fall); else n_pass++;
            clr = $urandom;
            bus_write(A_RISE, clr, 4'hF);
            m_rise &= ~clr;
            clr = $urandom;
            bus_write(A_FALL, clr, 4'hF);
            m_fall &= ~clr;
            m_en = $urandom & $urandom;
            bus_write(A_IREN, m_en, 4'hF);
            @(negedge clk);
            n_checks++; if (irq !== |((m_rise | m_fall) & m_en)) $display("FAIL rnd_irq[%0d] got %b exp %b", it, irq, |((m_rise | m_fall) & m_en)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic r;
        io = 32'h0;
        repeat (4) @(negedge clk);
        io = 32'hA5A5_0F0F;
        repeat (4) @(negedge clk);
        bus_write(A_IREN, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) $display("FAIL mid_irq_pre got %b exp 1", irq); else n_pass++;
        addr = A_DATA; ren = 1'b1;
        @(posedge clk); #2;
        n_checks++; if (ready !== 1'b1 || rdata !== 32'hA5A5_0F0F) $display("FAIL mid_pre got %b/%h exp 1/a5a50f0f", ready, rdata); else n_pass++;
        rst_n = 1'b0; ren = 1'b0; addr = 32'h0;
        #1;
        n_checks++; if (ready !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) $display("FAIL mid_reset got %b/%h/%b exp 0/0/0", ready, rdata, irq); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(A_RISE, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL mid_rise got %h exp 0", d); else n_pass++;
        bus_read(A_FALL, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL mid_fall got %h exp 0", d); else n_pass++;
        bus_read(A_IREN, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL mid_iren got %h exp 0", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL mid_irq got %b exp 0", irq); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; addr = 32'h0; wdata = 32'h0; wmask = 4'h0;
        ren = 1'b0; wen = 1'b0; io = 32'h0;
        m_rise = 32'h0; m_fall = 32'h0; m_en = 32'h0;
        @(negedge clk);
        test_reset;
        test_latency;
        test_w1c;
        test_collision;
        test_mask;
        test_decode;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
